// File: rtl/i2c_master_arbiter.sv
// Two-requester round-robin arbiter in front of an I2C master controller.
// Issues one start per transaction and supports locked repeated-START chains.
module i2c_master_arbiter #(
  parameter int START_TIMEOUT = 255,
  parameter int ADDR_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr_rw0,
  input  logic [ADDR_W-1:0] addr_rw1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic              start,
  output logic [ADDR_W-1:0] address_rw,
  output logic              Sr,
  input  logic              busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, FINISH} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(START_TIMEOUT - 1);

  state_t            state_r, state_s;
  logic [1:0]        gnt_r, gnt_s;
  logic [1:0]        done_r, done_s;
  logic [1:0]        err_r, err_s;
  logic              owner_r, owner_s;
  logic              last_r, last_s;
  logic              start_r, start_s;
  logic              sr_r, sr_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [7:0]        cnt_r, cnt_s;
  logic              winner_s;
  logic              owner_req_s;
  logic              owner_lock_s;
  logic [ADDR_W-1:0] owner_addr_s;

  function automatic logic [1:0] onehot2(input logic sel);
    onehot2 = sel ? 2'b10 : 2'b01;
  endfunction

  // Round-robin winner and current-owner input selection
  always_comb begin
    if (req0 && req1) begin
      winner_s = ~last_r;
    end else begin
      winner_s = req1;
    end
    owner_req_s  = owner_r ? req1 : req0;
    owner_lock_s = owner_r ? lock1 : lock0;
    owner_addr_s = owner_r ? addr_rw1 : addr_rw0;
  end

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    owner_s = owner_r;
    last_s  = last_r;
    start_s = 1'b0;
    sr_s    = sr_r;
    addr_s  = addr_r;
    done_s  = 2'b00;
    err_s   = 2'b00;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          state_s = ISSUE;
          owner_s = winner_s;
          gnt_s   = onehot2(winner_s);
          addr_s  = winner_s ? addr_rw1 : addr_rw0;
          start_s = 1'b1;
          sr_s    = 1'b0;
        end else begin
          gnt_s = 2'b00;
        end
      end
      ISSUE: begin
        state_s = WAIT_BUSY;
        cnt_s   = 8'd0;
      end
      WAIT_BUSY: begin
        if (busy) begin
          state_s = WAIT_DONE;
          cnt_s   = 8'd0;
        end else if (cnt_r >= TIMEOUT_LAST) begin
          // Controller never acknowledged: release the bus and report
          state_s = IDLE;
          gnt_s   = 2'b00;
          err_s   = onehot2(owner_r);
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!busy) begin
          state_s = FINISH;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      FINISH: begin
        done_s = onehot2(owner_r);
        last_s = owner_r;
        if (owner_lock_s && owner_req_s) begin
          state_s = ISSUE;
          addr_s  = owner_addr_s;
          start_s = 1'b1;
          sr_s    = 1'b1;
        end else begin
          state_s = IDLE;
          gnt_s   = 2'b00;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 2'b00;
      end
    endcase
  end

  // State and registered-output update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      gnt_r   <= 2'b00;
      owner_r <= 1'b0;
      last_r  <= 1'b1;
      start_r <= 1'b0;
      sr_r    <= 1'b0;
      addr_r  <= '0;
      done_r  <= 2'b00;
      err_r   <= 2'b00;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      owner_r <= owner_s;
      last_r  <= last_s;
      start_r <= start_s;
      sr_r    <= sr_s;
      addr_r  <= addr_s;
      done_r  <= done_s;
      err_r   <= err_s;
      cnt_r   <= cnt_s;
    end
  end

  assign gnt0       = gnt_r[0];
  assign gnt1       = gnt_r[1];
  assign done0      = done_r[0];
  assign done1      = done_r[1];
  assign err0       = err_r[0];
  assign err1       = err_r[1];
  assign start      = start_r;
  assign Sr         = sr_r;
  assign address_rw = addr_r;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: cycle vectors, directed corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_i2c_master_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, lock0, lock1;
  logic [7:0] addr_rw0, addr_rw1;
  logic       gnt0, gnt1, done0, done1, err0, err1, start, Sr;
  logic [7:0] address_rw;
  logic       busy, busy_t, busy_m, use_tbl;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // responder (master controller model) state
  int r_phase = 0, r_cnt = 0, r_fall_cyc = 0;
  bit r_never = 1'b0;

  assign busy = use_tbl ? busy_t : busy_m;

  i2c_master_arbiter #(.START_TIMEOUT(4), .ADDR_W(8)) dut (
    .clk(clk), .reset(rst_n),
    .req0(req0), .req1(req1), .addr_rw0(addr_rw0), .addr_rw1(addr_rw1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .start(start), .address_rw(address_rw),
    .Sr(Sr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       r0;
    logic       r1;
    logic [7:0] a0;
    logic [7:0] a1;
    logic       busy;
    logic [7:0] flags;  // {gnt0,gnt1,start,done0,done1,err0,err1,Sr}
    logic [7:0] ar;
  } vec_t;

  vec_t tbl [22];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_out(input string name, input logic [7:0] exp_flags, input logic [7:0] exp_ar);
    logic [7:0] act_flags;
    act_flags = {gnt0, gnt1, start, done0, done1, err0, err1, Sr};
    checks++;
    if (act_flags !== exp_flags || address_rw !== exp_ar) begin
      errors++;
      $display("FAIL %s: got flags=%b addr=%h, want flags=%b addr=%h",
               name, act_flags, address_rw, exp_flags, exp_ar);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    addr_rw0 = 8'h00; addr_rw1 = 8'h00; busy_t = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic [1:0] oh(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  // Master controller model: answers each start with a busy pulse, or never
  initial begin
    busy_m = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        busy_m  = 1'b0;
        r_phase = 0;
      end else begin
        case (r_phase)
          0: begin
            if (start && !use_tbl) begin
              r_never = ($urandom_range(0, 7) == 0);
              if (!r_never) begin
                r_cnt   = $urandom_range(1, 3);
                r_phase = 1;
              end
            end
          end
          1: begin
            r_cnt--;
            if (r_cnt == 0) begin
              busy_m  = 1'b1;
              r_cnt   = $urandom_range(1, 6);
              r_phase = 2;
            end
          end
          2: begin
            r_cnt--;
            if (r_cnt == 0) begin
              busy_m     = 1'b0;
              r_fall_cyc = cyc;
              r_phase    = 0;
            end
          end
          default: r_phase = 0;
        endcase
      end
    end
  end

  initial begin
    logic       rq [2];
    logic       lk [2];
    logic [7:0] ad [2];
    bit         pend [2];
    logic [1:0] g, dn, er;
    int         last_m, owner_m, start_cyc, w;
    bit         active, stop_new;
    logic       sr_m;
    logic [7:0] ar_m;

    use_tbl = 1'b1;
    do_reset();
    expect_out("reset_state", 8'b0000_0000, 8'h00);

    // single request, contention and round-robin vectors
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'hA0, 8'h00, 1'b0, 8'b1010_0000, 8'hA0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'hA0, 8'h00, 1'b0, 8'b1000_0000, 8'hA0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'hA0, 8'h00, 1'b0, 8'b1000_0000, 8'hA0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'hA0, 8'h00, 1'b1, 8'b1000_0000, 8'hA0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'hA0, 8'h00, 1'b1, 8'b1000_0000, 8'hA0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'hA0, 8'h00, 1'b1, 8'b1000_0000, 8'hA0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'hA0, 8'h00, 1'b0, 8'b1000_0000, 8'hA0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'hA0, 8'h00, 1'b0, 8'b0001_0000, 8'hA0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'hA0, 8'h00, 1'b0, 8'b0000_0000, 8'hA0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'b0000_0000, 8'h00};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 8'h50, 8'h51, 1'b0, 8'b1010_0000, 8'h50};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 8'h50, 8'h51, 1'b1, 8'b1000_0000, 8'h50};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 8'h50, 8'h51, 1'b1, 8'b1000_0000, 8'h50};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 8'h50, 8'h51, 1'b0, 8'b1000_0000, 8'h50};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 8'h50, 8'h51, 1'b0, 8'b0001_0000, 8'h50};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 8'h50, 8'h51, 1'b0, 8'b0110_0000, 8'h51};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 8'h50, 8'h51, 1'b1, 8'b0100_0000, 8'h51};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 8'h50, 8'h51, 1'b1, 8'b0100_0000, 8'h51};
    tbl[18] = '{1'b1, 1'b0, 1'b1, 8'h50, 8'h51, 1'b0, 8'b0100_0000, 8'h51};
    tbl[19] = '{1'b1, 1'b0, 1'b1, 8'h50, 8'h51, 1'b0, 8'b0000_1000, 8'h51};
    tbl[20] = '{1'b1, 1'b1, 1'b1, 8'h50, 8'h51, 1'b0, 8'b1010_0000, 8'h50};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'b0000_0000, 8'h00};

    for (int i = 0; i < 22; i++) begin
      rst_n = tbl[i].rst_n;
      req0 = tbl[i].r0; req1 = tbl[i].r1;
      addr_rw0 = tbl[i].a0; addr_rw1 = tbl[i].a1;
      busy_t = tbl[i].busy;
      tick();
      expect_out($sformatf("vec%0d", i), tbl[i].flags, tbl[i].ar);
    end

    // locked requester 1: repeated START, requester 0 held off
    do_reset();
    rst_n = 1'b1; req1 = 1'b1; lock1 = 1'b1; addr_rw1 = 8'h90;
    tick(); expect_out("lock_issue1", 8'b0110_0000, 8'h90);
    req0 = 1'b1; addr_rw0 = 8'h30;
    tick(); expect_out("lock_wait_busy1", 8'b0100_0000, 8'h90);
    busy_t = 1'b1;
    tick(); expect_out("lock_wait_done1", 8'b0100_0000, 8'h90);
    addr_rw1 = 8'h91; busy_t = 1'b0;
    tick(); expect_out("lock_finish1", 8'b0100_0000, 8'h90);
    tick(); expect_out("lock_reissue", 8'b0110_1001, 8'h91);
    lock1 = 1'b0; req1 = 1'b0;
    tick(); expect_out("lock_wait_busy2", 8'b0100_0001, 8'h91);
    busy_t = 1'b1;
    tick(); expect_out("lock_wait_done2", 8'b0100_0001, 8'h91);
    busy_t = 1'b0;
    tick(); expect_out("lock_finish2", 8'b0100_0001, 8'h91);
    tick(); expect_out("lock_done2", 8'b0000_1001, 8'h91);
    tick(); expect_out("lock_then_req0", 8'b1010_0000, 8'h30);

    // start timeout: busy never rises
    do_reset();
    rst_n = 1'b1; req0 = 1'b1; addr_rw0 = 8'hC3;
    tick(); expect_out("to_issue", 8'b1010_0000, 8'hC3);
    for (int k = 0; k < 4; k++) begin
      tick(); expect_out($sformatf("to_wait%0d", k), 8'b1000_0000, 8'hC3);
    end
    tick(); expect_out("to_err", 8'b0000_0100, 8'hC3);
    req0 = 1'b0;
    tick(); expect_out("to_idle1", 8'b0000_0000, 8'hC3);
    tick(); expect_out("to_idle2", 8'b0000_0000, 8'hC3);

    // reset in the middle of a transaction
    do_reset();
    rst_n = 1'b1; req1 = 1'b1; addr_rw1 = 8'h77;
    tick(); expect_out("rst_issue", 8'b0110_0000, 8'h77);
    busy_t = 1'b1;
    tick(); expect_out("rst_wait_busy", 8'b0100_0000, 8'h77);
    tick(); expect_out("rst_wait_done", 8'b0100_0000, 8'h77);
    tick();
    rst_n = 1'b0;
    #1;
    expect_out("rst_abort", 8'b0000_0000, 8'h00);
    busy_t = 1'b0;
    tick(); expect_out("rst_held1", 8'b0000_0000, 8'h00);
    tick(); expect_out("rst_held2", 8'b0000_0000, 8'h00);
    rst_n = 1'b1;
    tick(); expect_out("rst_regrant", 8'b0110_0000, 8'h77);

    // randomized traffic against the transaction-level model
    do_reset();
    use_tbl = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0; lk[i] = 1'b0; ad[i] = 8'h00; pend[i] = 1'b0;
    end
    last_m = 1; owner_m = 0; start_cyc = 0; active = 1'b0; stop_new = 1'b0;
    sr_m = 1'b0; ar_m = 8'h00;

    for (int c = 0; c < 2600; c++) begin
      tick();
      g = {gnt1, gnt0}; dn = {done1, done0}; er = {err1, err0};
      chk("gnt_exclusive", int'(g == 2'b11), 0);
      if (active) begin
        if (dn != 2'b00) begin
          chk("done_owner", int'(dn), int'(oh(owner_m)));
          chk("done_not_timeout", int'(r_never), 0);
          chk("done_latency", int'((cyc - r_fall_cyc) >= 2), 1);
          chk("done_no_err", int'(er), 0);
          last_m = owner_m;
          if (rq[owner_m] && lk[owner_m]) begin
            chk("reissue_start", int'(start), 1);
            chk("reissue_gnt", int'(g), int'(oh(owner_m)));
            sr_m = 1'b1; ar_m = ad[owner_m]; start_cyc = cyc;
          end else begin
            chk("finish_start", int'(start), 0);
            chk("finish_gnt", int'(g), 0);
            active = 1'b0;
          end
        end else if (er != 2'b00) begin
          chk("err_owner", int'(er), int'(oh(owner_m)));
          chk("err_expected", int'(r_never), 1);
          chk("err_latency", cyc - start_cyc, 5);
          chk("err_gnt", int'(g), 0);
          chk("err_start", int'(start), 0);
          active = 1'b0;
        end else begin
          chk("hold_gnt", int'(g), int'(oh(owner_m)));
          chk("single_start", int'(start), 0);
          chk("txn_watchdog", int'((cyc - start_cyc) <= 40), 1);
          if ((cyc - start_cyc) > 40) active = 1'b0;
        end
      end else begin
        chk("idle_done", int'(dn), 0);
        chk("idle_err", int'(er), 0);
        if (start) begin
          chk("start_has_req", int'(rq[0] || rq[1]), 1);
          if (rq[0] && rq[1]) w = (last_m == 0) ? 1 : 0;
          else w = rq[1] ? 1 : 0;
          chk("rr_gnt", int'(g), int'(oh(w)));
          owner_m = w; sr_m = 1'b0; ar_m = ad[w]; start_cyc = cyc; active = 1'b1;
        end else begin
          chk("idle_gnt", int'(g), 0);
        end
      end
      chk("sr_value", int'(Sr), int'(sr_m));
      chk("addr_value", int'(address_rw), int'(ar_m));

      if (c >= 2300) stop_new = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (er[i]) begin
          rq[i] = 1'b0; lk[i] = 1'b0; pend[i] = 1'b0;
        end else if (dn[i]) begin
          if (!(rq[i] && !stop_new && $urandom_range(0, 1) == 0)) begin
            rq[i] = 1'b0; lk[i] = 1'b0; pend[i] = 1'b0;
          end
        end else if (!pend[i]) begin
          if (!stop_new && $urandom_range(0, 3) == 0) begin
            rq[i] = 1'b1; pend[i] = 1'b1;
            ad[i] = 8'($urandom_range(0, 255));
            lk[i] = ($urandom_range(0, 2) == 0);
          end
        end else if (active && owner_m == i && rq[i] && $urandom_range(0, 19) == 0) begin
          rq[i] = 1'b0; lk[i] = 1'b0;
        end
      end
      req0 = rq[0]; req1 = rq[1];
      lock0 = lk[0]; lock1 = lk[1];
      addr_rw0 = ad[0]; addr_rw1 = ad[1];
    end
    chk("drain_idle", int'(active), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_arbiter.md
I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- START_TIMEOUT, 255, max clk cycles to wait for busy rise after start; range 1..255.
- ADDR_W, 8, width of address/R-W word.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  input  1  system clock, single clock domain.
- reset  input  1  asynchronous, active-low reset.
- req0 / req1  input  1  requester 0/1 transaction request, level, held until done/err.
- addr_rw0 / addr_rw1  input  ADDR_W  requester address + R/W bit, stable while req high.
- lock0 / lock1  input  1  requester keeps the bus after done; next transaction uses repeated START.
- gnt0 / gnt1  output  1  grant, one-hot or zero.
- done0 / done1  output  1  one-cycle completion pulse.
- err0 / err1  output  1  one-cycle timeout pulse.
- start  output  1  one-cycle start pulse to the master controller.
- address_rw  output  ADDR_W  latched address/R-W word to the master controller.
- Sr  output  1  repeated-START flag to the master controller, valid with start.
- busy  input  1  master controller busy.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, FINISH.
REQ-004 IDLE: if any req is high, the arbiter SHALL select the winner, set its gnt, latch its addr_rw into address_rw, and go to ISSUE on the next edge.
REQ-005 Arbitration SHALL be round-robin: a single req wins; on simultaneous req the requester not served last wins; the pointer after reset SHALL favour requester 0.
REQ-006 ISSUE SHALL last exactly one cycle with start=1, then go to WAIT_BUSY.
REQ-007 Sr SHALL be 0 for a transaction entered from IDLE and 1 for a transaction re-issued under lock (REQ-011), and SHALL hold its value until the next ISSUE.
REQ-008 WAIT_BUSY: busy=1 SHALL go to WAIT_DONE. An 8-bit counter SHALL reach START_TIMEOUT without busy; the FSM SHALL then pulse err of the owner for one cycle, drop gnt, and return to IDLE.
REQ-009 WAIT_DONE: busy=0 SHALL go to FINISH. There SHALL be no timeout in this state.
REQ-010 FINISH SHALL pulse done of the owner for one cycle and update the round-robin pointer to the owner.
REQ-011 In FINISH, if owner lock=1 and owner req=1, the arbiter SHALL latch owner addr_rw, keep gnt, and go to ISSUE with Sr=1. Otherwise it SHALL drop gnt and go to IDLE.
REQ-012 If the owner drops req before done, the arbiter SHALL ignore the drop and complete the transaction. The other requester SHALL never preempt an active or locked owner.
REQ-013 address_rw SHALL change only in IDLE->ISSUE or FINISH->ISSUE transitions.
REQ-014 gnt0 and gnt1 SHALL never both be 1. done, err and start SHALL each be 1 for at most one cycle per transaction.
REQ-015 Minimum latency SHALL be as follows: req rise at edge N -> gnt and address_rw at N+1, start at N+1..N+2 (the ISSUE cycle), done no earlier than 2 cycles after busy falls.

Reset
REQ-016 While reset=0: state=IDLE; gnt0=gnt1=0; start=0; Sr=0; done0=done1=err0=err1=0; address_rw=0; timeout counter=0; RR pointer=favour 0.
REQ-017 Assertion of reset mid-transaction SHALL abort immediately, with no done/err pulse. Operation SHALL resume from IDLE on the first edge after release.

Verification
REQ-018 Single request: req0=1, addr_rw0=0xA0; busy high 2 cycles after start, low 20 cycles later -> gnt0, one start with address_rw=0xA0 and Sr=0, one done0, then gnt0=0.
REQ-019 Contention: req0=req1=1 from reset, 0x50/0x51 -> requester 0 served first, then requester 1 with address_rw=0x51; a further simultaneous request is served by requester 0.
REQ-020 Lock: lock1=1, req1 held, two transactions 0x90 then 0x91 -> second start has Sr=1, gnt1 stays high between them, req0 raised meanwhile is not granted until lock1 and req1 drop.
REQ-021 Timeout: START_TIMEOUT=4, busy never rises -> err0 pulse 4 cycles after WAIT_BUSY entry, no done0, FSM back in IDLE.
REQ-022 Reset mid-operation: reset=0 during WAIT_DONE -> all outputs zero at once, no done pulse; after release a pending req1 is granted normally.
